alu_result_stage: RTL

- Registered output stage directly downstream of the combinational 32-bit ALU.
- Captures the ALU result and its opcode with a valid/ready handshake, and derives status flags.
- A 2-entry skid buffer (main + skid register) keeps full throughput while isolating downstream backpressure from the ALU.
- Maintains a saturating count of delivered results.

---
 rtl/alu_result_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the 32-bit ALU.
// Two-entry skid buffer (main + skid) with valid/ready on both sides.
// Status flags are computed once at capture and travel with the entry.
// A saturating counter tracks delivered results.
module alu_result_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_result,
  input  logic [3:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [3:0]           out_op,
  output logic                 out_zero,
  output logic                 out_neg,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] result_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       op;
    logic             zero;
    logic             neg;
    logic             illegal;
  } entry_t;

  state_t state_q;
  state_t state_d;
  entry_t in_entry_p0;
  entry_t main_p1;
  entry_t skid_p1;
  logic   in_fire;
  logic   out_fire;

  // Build a buffer entry with its flags derived from the raw ALU output.
  function automatic entry_t make_entry(input logic [WIDTH-1:0] r,
                                        input logic [3:0]       op);
    entry_t e;
    e.result  = r;
    e.op      = op;
    e.zero    = (r == '0);
    e.neg     = r[WIDTH-1];
    e.illegal = (op > 4'b0110);
    return e;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c) return c;
    return c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign in_entry_p0 = make_entry(in_result, in_op);

  assign out_result  = main_p1.result;
  assign out_op      = main_p1.op;
  assign out_zero    = main_p1.zero;
  assign out_neg     = main_p1.neg;
  assign out_illegal = main_p1.illegal;

  // Next-state decision for the skid buffer occupancy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_fire) state_d = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_d = FULL;
        else if (!in_fire && out_fire) state_d = EMPTY;
      end
      FULL: if (out_fire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // p0 -> p1: capture into main/skid, register handshake outputs and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_p1      <= '0;
      skid_p1      <= '0;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      result_count <= '0;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) main_p1 <= in_entry_p0;
        ONE: begin
          if (in_fire && out_fire) main_p1 <= in_entry_p0;
          else if (in_fire)        skid_p1 <= in_entry_p0;
        end
        FULL: if (out_fire) main_p1 <= skid_p1;
        default: ;
      endcase
      state_q   <= state_d;
      out_valid <= (state_d != EMPTY);
      in_ready  <= (state_d != FULL);
      if (out_fire) result_count <= sat_inc(result_count);
    end
  end

endmodule
